uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receiver: the consuming stage for the auto-send UART transmitter on the far end of the link (loopback or RS485 receive path).
- Synchronises the asynchronous rx line and detects 8N1 frames by mid-bit sampling.
- Presents each received byte with a one-cycle valid strobe, plus framing-error and busy status, to on-board logic and test harnesses.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division), clock cycles per bit. Derived localparam; must be >= 8.

Ports:
- clk  input  1  system clock (the PLL 50 MHz output).
- rst_n  input  1  reset, synchronous, active-low.
- uart_rxd  input  1  asynchronous serial input; idle high.
- rx_data  output  8  last correctly received byte, LSB first on the line.
- rx_valid  output  1  one-cycle strobe; rx_data is new this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- parity_err  output  1  one-cycle strobe; parity mismatch (see Optional Feature).
- rx_busy  output  1  high while a frame is being received.

Behaviour:
- Reset (rst_n low at a clk edge):
  - sync flops = 1; state = IDLE; counters = 0.
  - rx_data = 8'h00; rx_valid = frame_err = parity_err = rx_busy = 0.
  - Reset mid-frame abandons the frame with no strobe.
- Input sync: two-flop synchroniser; all decisions use the second flop (rxd_s). Fixed 2-cycle input latency.
- bit_cnt: 0..CLKS_PER_BIT-1, restarted on every state entry. idx: 0..7 data bit index.
- IDLE:
  - rx_busy = 0.
  - rxd_s == 0 -> START.
- START:
  - rx_busy = 1.
  - At bit_cnt == CLKS_PER_BIT/2 - 1, sample rxd_s.
  - Sample 1 -> IDLE, no strobe (glitch rejection).
  - Sample 0 -> DATA, counter restarts. Sampling is now at mid-bit.
- DATA:
  - At bit_cnt == CLKS_PER_BIT-1, shift rxd_s into the MSB of shift register sr (right shift); idx += 1.
  - After the 8th sample -> STOP (or PARITY when the macro is defined).
- STOP, at bit_cnt == CLKS_PER_BIT-1, sample rxd_s:
  - Sample 1: rx_data <= sr; rx_valid pulses for the next cycle; -> IDLE.
    - The next start bit is accepted immediately, so back-to-back frames with zero idle time are supported.
  - Sample 0: frame_err pulses; rx_data is unchanged; -> BREAK.
- BREAK:
  - rx_busy = 1; wait for rxd_s == 1, then -> IDLE.
  - A held-low line produces exactly one frame_err and no further frames.
- Strobes:
  - Never asserted for more than one cycle.
  - rx_valid and frame_err are never high together.
  - parity_err, when asserted, is coincident with rx_valid.
- Latency: the rx_valid rising edge is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+1 with parity) cycles after the uart_rxd falling edge, ±1.
- No output buffering: a new byte overwrites rx_data; the consumer must take it on rx_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD, default 0 (0 = even parity, 1 = odd parity).
  - Adds state PARITY between DATA and STOP, sampling one bit at bit_cnt == CLKS_PER_BIT-1.
  - Expected parity bit = ^sr ^ PARITY_ODD.
  - Mismatch: parity_err pulses together with rx_valid at a good stop bit. The byte is still delivered.
  - A bad stop bit gives frame_err only.
- Not defined: 8N1 only; parity_err tied to 0. The port is kept so the interface is identical in both builds.

Test Plan:
- Bench override: BAUD_RATE = 3_125_000, so CLKS_PER_BIT = 16.
- Reset: hold rst_n low 5 cycles with uart_rxd = 0 -> all outputs 0 and rx_data = 8'h00; release rst_n with line high -> no strobe.
- Single byte: drive 8'hA5 in 8N1 -> exactly one rx_valid, rx_data = 8'hA5, latency 2+8+144 = 154 ±1 cycles, rx_busy high throughout the frame.
- Back-to-back: 8'h00, 8'hFF, 8'h55 with zero idle bits -> three rx_valid strobes with data in order, no frame_err.
- Glitch and framing:
  - 4-cycle low pulse on an idle line -> no strobe; rx_busy returns to 0 after the START sample.
  - Frame 8'h3C with stop bit forced 0, then line held low for 40 bit times -> one frame_err, rx_data keeps its previous value, then 8'h81 is received correctly after the line is released.
- Reset mid-frame: assert rst_n at data bit 4 of 8'hC3 -> no strobe, state IDLE; the next frame 8'h12 is received correctly.
- Parity (UART_RX_PARITY_EN, PARITY_ODD = 0):
  - 8'h07 with parity bit 1 -> rx_valid, parity_err = 0.
  - Same frame with parity bit 0 -> rx_valid and parity_err together, rx_data = 8'h07.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with mid-bit sampling, glitch rejection and break handling.
// Ports: clk, rst_n (sync, active-low), uart_rxd (async, idle high) in;
//        rx_data[7:0], rx_valid, frame_err, parity_err, rx_busy out.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sr_q, sr_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          rxd_s;
`ifdef UART_RX_PARITY_EN
  logic          bad_q, bad_d, perr_q, perr_d;
`endif
  assign rxd_s = sync_q[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      bad_q   <= bad_d;
      perr_q  <= perr_d;
`endif
    end
  end
  always_comb begin
    sync_d  = {sync_q[0], uart_rxd};
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_d   = bad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      // Half-bit check re-aligns all later samples to mid-bit and rejects short glitches.
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sr_d  = {rxd_s, sr_q[7:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL) begin
        cnt_d   = '0;
        bad_d   = rxd_s != (^sr_q ^ PARITY_ODD);
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        if (rxd_s) begin
          data_d  = sr_q;
          valid_d = 1'b1;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          perr_d  = bad_q;
`endif
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      // A line held low after a bad stop bit must not be mistaken for new start bits.
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_busy   = state_q != IDLE;
    rx_data   = data_q;
    rx_valid  = valid_q;
    frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    parity_err = perr_q;
`else
    parity_err = 1'b0;
`endif
  end
endmodule
